baser_257b_descrambler: RTL and testbench

Receive-side self-synchronizing descrambler for 257b transcoded BASE-R blocks, polynomial G(x)=1+x^39+x^58. It takes scrambled 257b blocks from the scrambled output of `PCS_generator` or the lane deskew path, and delivers pre-scrambler 257b blocks to `BASER_257b_checker` through `i_rx_coded`. It tracks descrambler seeding, qualifies its output with a valid strobe, and counts delivered blocks.

---
 rtl/baser_pkg.sv | 43 ++++
 rtl/baser_257b_descrambler.sv | 85 ++++++++
 tb/tb_baser_257b_descrambler.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/baser_pkg.sv
// Shared constants and bit-serial reference functions for the 257b BASE-R
// scrambler/descrambler, polynomial G(x) = 1 + x^39 + x^58.
package baser_pkg;

    localparam int TC_WIDTH = 257;
    localparam int SCR_LEN  = 58;
    localparam int SCR_TAP  = 39;

    typedef enum logic {
        UNSYNC = 1'b0,
        SYNC   = 1'b1
    } scr_state_e;

    // e[SCR_LEN-1:0] is the history, e[SCR_LEN+i] is scrambled bit i of this block.
    function automatic logic [TC_WIDTH-1:0] descramble_257b(
        input logic [SCR_LEN-1:0]  state,
        input logic [TC_WIDTH-1:0] block
    );
        logic [TC_WIDTH+SCR_LEN-1:0] e;
        logic [TC_WIDTH-1:0]         out;
        e   = {block, state};
        out = '0;
        for (int i = 0; i < TC_WIDTH; i++) begin
            out[i] = e[i+SCR_LEN] ^ e[i+SCR_LEN-SCR_TAP] ^ e[i];
        end
        return out;
    endfunction

    // Inverse of descramble_257b: each output bit feeds back into the history.
    function automatic logic [TC_WIDTH-1:0] scramble_257b(
        input logic [SCR_LEN-1:0]  state,
        input logic [TC_WIDTH-1:0] block
    );
        logic [TC_WIDTH+SCR_LEN-1:0] e;
        e = '0;
        e[SCR_LEN-1:0] = state;
        for (int i = 0; i < TC_WIDTH; i++) begin
            e[i+SCR_LEN] = block[i] ^ e[i+SCR_LEN-SCR_TAP] ^ e[i];
        end
        return e[TC_WIDTH+SCR_LEN-1:SCR_LEN];
    endfunction

endpackage

// File: rtl/baser_257b_descrambler.sv
// Self-synchronizing 257b descrambler: seeds on the first block after
// reset/resync, then delivers one descrambled block per accepted input.
module baser_257b_descrambler #(
    parameter int TC_WIDTH  = baser_pkg::TC_WIDTH,
    parameter int SCR_LEN   = baser_pkg::SCR_LEN,
    parameter int SCR_TAP   = baser_pkg::SCR_TAP,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    input  logic [TC_WIDTH-1:0]  i_rx_scrambled,
    input  logic                 i_bypass,
    input  logic                 i_resync,
    output logic [TC_WIDTH-1:0]  o_rx_coded,
    output logic                 o_valid,
    output logic                 o_sync,
    output logic [CNT_WIDTH-1:0] o_block_count
);
    import baser_pkg::*;

    // The datapath is the package function, so the geometry must match it.
    if (TC_WIDTH != baser_pkg::TC_WIDTH || SCR_LEN != baser_pkg::SCR_LEN ||
        SCR_TAP != baser_pkg::SCR_TAP) begin : g_bad_geometry
        $error("baser_257b_descrambler: parameters must match baser_pkg");
    end

    scr_state_e           state_q, state_d;
    logic [SCR_LEN-1:0]   scr_q, scr_d;
    logic [TC_WIDTH-1:0]  data_q, data_d;
    logic                 vld_q, vld_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 deliver;

    always_comb begin
        state_d = state_q;
        scr_d   = scr_q;
        data_d  = data_q;
        vld_d   = 1'b0;
        cnt_d   = cnt_q;
        deliver = 1'b0;

        if (i_valid) begin
            scr_d   = i_rx_scrambled[TC_WIDTH-1 -: SCR_LEN];
            deliver = i_bypass || (state_q == SYNC && !i_resync);
            state_d = SYNC;
            if (deliver) begin
                data_d = i_bypass ? i_rx_scrambled
                                  : descramble_257b(scr_q, i_rx_scrambled);
                vld_d  = 1'b1;
            end
        end

        // Resync wins over the seeding/delivery of a concurrent block.
        if (i_resync) begin
            state_d = UNSYNC;
        end

        if (vld_d && cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= UNSYNC;
            scr_q   <= '0;
            data_q  <= '0;
            vld_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            scr_q   <= scr_d;
            data_q  <= data_d;
            vld_q   <= vld_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_rx_coded    = data_q;
    assign o_valid       = vld_q;
    assign o_sync        = (state_q == SYNC);
    assign o_block_count = cnt_q;

endmodule

// File: tb/tb_baser_257b_descrambler.sv
// Scoreboard bench for baser_257b_descrambler: the driver queues expected
// blocks, a negedge monitor pops and compares them against o_rx_coded.
module tb_baser_257b_descrambler;
    localparam int W  = 257;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_valid = 1'b0;
    logic [W-1:0]  i_rx_scrambled = '0;
    logic          i_bypass = 1'b0;
    logic          i_resync = 1'b0;
    logic [W-1:0]  o_rx_coded;
    logic          o_valid;
    logic          o_sync;
    logic [CW-1:0] o_block_count;

    logic [W-1:0]  exp_q[$];
    logic [CW-1:0] exp_cnt = '0;
    int            ntests = 0;
    int            nfail  = 0;

    baser_257b_descrambler #(.CNT_WIDTH(CW)) dut (
        .clk           (clk),
        .i_rst         (i_rst),
        .i_valid       (i_valid),
        .i_rx_scrambled(i_rx_scrambled),
        .i_bypass      (i_bypass),
        .i_resync      (i_resync),
        .o_rx_coded    (o_rx_coded),
        .o_valid       (o_valid),
        .o_sync        (o_sync),
        .o_block_count (o_block_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every presented block must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!i_rst && o_valid) begin
            if (exp_q.size() == 0) begin
                ntests++;
                nfail++;
                $display("FAIL unexpected_valid: got %h expected no block", o_rx_coded);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                if (exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
                chk("rx_coded", o_rx_coded, e);
                chk("block_count", W'(o_block_count), W'(exp_cnt));
            end
        end
    end

    task automatic blk(input logic [W-1:0] d, input logic byp, input logic rs,
                       input logic dl, input logic [W-1:0] exp);
        i_valid        = 1'b1;
        i_rx_scrambled = d;
        i_bypass       = byp;
        i_resync       = rs;
        if (dl) exp_q.push_back(exp);
        @(posedge clk);
        #1;
        i_valid  = 1'b0;
        i_bypass = 1'b0;
        i_resync = 1'b0;
    endtask

    function automatic logic [W-1:0] rnd();
        logic [W-1:0] r;
        for (int b = 0; b < W; b++) r[b] = 1'($urandom_range(0, 1));
        return r;
    endfunction

    task automatic do_reset();
        i_rst = 1'b1;
        exp_q.delete();
        exp_cnt = '0;
        @(posedge clk);
        #1;
        i_rst = 1'b0;
    endtask

    initial begin
        logic [W-1:0]  z, b0, e0, b256, e256, pat, e_pat, p, s;
        logic [57:0]   ss;
        z = '0;
        b0 = '0;   b0[0] = 1'b1;
        e0 = '0;   e0[0] = 1'b1; e0[39] = 1'b1; e0[58] = 1'b1;
        b256 = '0; b256[256] = 1'b1;
        e256 = '0; e256[38] = 1'b1; e256[57] = 1'b1;
        pat = {1'b1, {64{4'h5}}};
        // State after pat = odd bits 1..57 set; with a zero block this gives
        // bits 0..38 all ones and the odd bits 39..57.
        e_pat = '0;
        for (int i = 0; i < 39; i++) e_pat[i] = 1'b1;
        for (int i = 39; i < 58; i++) e_pat[i] = 1'(i % 2);

        // Reset state (asynchronous, before any clock edge)
        #2;
        chk("rst_coded", o_rx_coded, z);
        chk("rst_valid", W'(o_valid), W'(0));
        chk("rst_sync", W'(o_sync), W'(0));
        chk("rst_count", W'(o_block_count), W'(0));
        do_reset();

        // Seeding block is swallowed, sync rises on that edge
        blk(z, 1'b0, 1'b0, 1'b0, z);
        chk("seed_sync", W'(o_sync), W'(1));
        chk("seed_valid", W'(o_valid), W'(0));
        blk(z, 1'b0, 1'b0, 1'b1, z);
        blk(b0, 1'b0, 1'b0, 1'b1, e0);
        blk(z, 1'b0, 1'b0, 1'b1, z);
        blk(b256, 1'b0, 1'b0, 1'b1, b256);
        blk(z, 1'b0, 1'b0, 1'b1, e256);

        // Scrambled stream after reset: block 1 seeds, blocks 2..20 recover
        do_reset();
        ss = 58'(rnd());
        for (int k = 0; k < 20; k++) begin
            p  = rnd();
            s  = baser_pkg::scramble_257b(ss, p);
            ss = s[256:199];
            blk(s, 1'b0, 1'b0, (k != 0), p);
        end

        // Resync with a concurrent block: consumed, not delivered, sync drops
        blk(rnd(), 1'b0, 1'b1, 1'b0, z);
        chk("resync_sync", W'(o_sync), W'(0));
        chk("resync_valid", W'(o_valid), W'(0));
        blk(z, 1'b0, 1'b0, 1'b0, z);
        chk("reseed_sync", W'(o_sync), W'(1));
        blk(b0, 1'b0, 1'b0, 1'b1, e0);

        // Bypass toggled mid-stream; the bypassed block still loads the state
        blk(pat, 1'b1, 1'b0, 1'b1, pat);
        blk(z, 1'b0, 1'b0, 1'b1, e_pat);

        // Burst that drives the count past saturation
        for (int k = 0; k < 15; k++) blk(z, 1'b0, 1'b0, 1'b1, z);
        @(negedge clk);
        chk("count_sat", W'(o_block_count), W'({CW{1'b1}}));

        // Bypass while UNSYNC is delivered
        i_resync = 1'b1;
        @(posedge clk);
        #1;
        i_resync = 1'b0;
        chk("idle_resync_sync", W'(o_sync), W'(0));
        blk(pat, 1'b1, 1'b0, 1'b1, pat);
        chk("bypass_valid", W'(o_valid), W'(1));
        chk("count_hold", W'(o_block_count), W'({CW{1'b1}}));

        // Reset mid-burst clears the in-flight block asynchronously
        blk(b0, 1'b1, 1'b0, 1'b1, b0);
        chk("inflight_pending", W'(exp_q.size()), W'(1));
        #2;
        i_rst = 1'b1;
        exp_q.delete();
        exp_cnt = '0;
        #1;
        chk("arst_coded", o_rx_coded, z);
        chk("arst_valid", W'(o_valid), W'(0));
        chk("arst_sync", W'(o_sync), W'(0));
        chk("arst_count", W'(o_block_count), W'(0));
        @(posedge clk);
        #1;
        i_rst = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
